// File: rtl/obi_qspi_arbiter.sv
// rtl/obi_qspi_arbiter.sv - two-port round-robin OBI arbiter in front of the QSPI flash controller
// Optional response timeout (and its TIMEOUT_CYCLES parameter) enabled by `define OBI_ARB_TIMEOUT_EN.

module obi_qspi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef OBI_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // port 0: instruction fetch
  input  logic              m0_req_i,
  output logic              m0_gnt_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_be_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,
  // port 1: data
  input  logic              m1_req_i,
  output logic              m1_gnt_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_be_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,
  // QSPI controller side
  output logic              s_req_o,
  input  logic              s_gnt_i,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic              s_we_o,
  output logic [3:0]        s_be_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_rvalid_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic              s_illegal_write_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    WRESP    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                s_req_q, s_req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                m0_rvalid_q, m0_rvalid_d;
  logic                m1_rvalid_q, m1_rvalid_d;
  logic                m0_err_q, m0_err_d;
  logic                m1_err_q, m1_err_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic                winner;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;

`ifdef OBI_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]         tmo_cnt_q, tmo_cnt_d;
`endif

  // Next-state logic: arbitration, transaction sequencing and response routing to the owner
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    m0_rvalid_d  = 1'b0;
    m1_rvalid_d  = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    rsp_err      = 1'b0;
`ifdef OBI_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    // With both requesting, the port that was not served last wins; otherwise the lone requester.
    winner = (m0_req_i && m1_req_i) ? ~last_owner_q : m1_req_i;

    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          owner_d      = winner;
          last_owner_d = winner;
          addr_d       = winner ? m1_addr_i  : m0_addr_i;
          we_d         = winner ? m1_we_i    : m0_we_i;
          be_d         = winner ? m1_be_i    : m0_be_i;
          wdata_d      = winner ? m1_wdata_i : m0_wdata_i;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (s_gnt_i) begin
          if (we_q) begin
            // Writes complete on grant; the response pulse lands in the WRESP cycle.
            rsp_valid = 1'b1;
            rsp_data  = '0;
            rsp_err   = s_illegal_write_i;
            state_d   = WRESP;
          end else begin
            state_d   = WAIT_RSP;
`ifdef OBI_ARB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
      end
      WAIT_RSP: begin
        if (s_rvalid_i) begin
          rsp_valid = 1'b1;
          rsp_data  = s_rdata_i;
          state_d   = IDLE;
        end
`ifdef OBI_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          rsp_valid = 1'b1;
          rsp_data  = DATA_W'(32'hDEAD_BEEF);
          rsp_err   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      WRESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rsp_valid) begin
      if (owner_q) begin
        m1_rvalid_d = 1'b1;
        m1_rdata_d  = rsp_data;
        m1_err_d    = rsp_err;
      end else begin
        m0_rvalid_d = 1'b1;
        m0_rdata_d  = rsp_data;
        m0_err_d    = rsp_err;
      end
    end

    s_req_d = (state_d == ISSUE);
  end

  // State and registered outputs; reset aborts any transaction in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      s_req_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      s_req_q      <= s_req_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

`ifdef OBI_ARB_TIMEOUT_EN
  // Response timeout counter, cleared on entry to WAIT_RSP
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign m0_gnt_o    = (state_q == ISSUE) && s_gnt_i && !owner_q;
  assign m1_gnt_o    = (state_q == ISSUE) && s_gnt_i &&  owner_q;
  assign s_req_o     = s_req_q;
  assign s_addr_o    = addr_q;
  assign s_we_o      = we_q;
  assign s_be_o      = be_q;
  assign s_wdata_o   = wdata_q;
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_err_o    = m0_err_q;
  assign m1_err_o    = m1_err_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_obi_qspi_arbiter.sv
// tb/tb_obi_qspi_arbiter.sv - directed self-checking bench for obi_qspi_arbiter

module tb_obi_qspi_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        m0_req_i, m1_req_i;
  logic        m0_gnt_o, m1_gnt_o;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_wdata_i, m1_wdata_i;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_err_o, m1_err_o;
  logic        s_req_o, s_gnt_i;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        s_illegal_write_i;

  int n_checks = 0;
  int n_fail   = 0;

  obi_qspi_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
`ifdef OBI_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_illegal_write_i(s_illegal_write_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_inputs();
    m0_req_i = 0; m1_req_i = 0; m0_addr_i = 0; m1_addr_i = 0;
    m0_we_i = 0; m1_we_i = 0; m0_be_i = 4'hF; m1_be_i = 4'hF;
    m0_wdata_i = 0; m1_wdata_i = 0;
    s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = 0; s_illegal_write_i = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_i = 1;
    cyc(); cyc();
    rst_i = 0;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst_i = 1;
    cyc(); cyc();
    n_checks++;
    if ({s_req_o, m0_gnt_o, m1_gnt_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_req_gnt: got %b expected 000", {s_req_o, m0_gnt_o, m1_gnt_o});
    end
    n_checks++;
    if ({m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_rvalid_err: got %b expected 0000", {m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o});
    end
    n_checks++;
    if ({m0_rdata_o, m1_rdata_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", {m0_rdata_o, m1_rdata_o});
    end
    n_checks++;
    if ({s_addr_o, s_we_o, s_be_o, s_wdata_o} !== 69'h0) begin
      n_fail++; $display("FAIL reset_latched: got %h expected 0", {s_addr_o, s_we_o, s_be_o, s_wdata_o});
    end
    rst_i = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h0000_0100;
    cyc();
    n_checks++;
    if ({s_req_o, s_addr_o, s_we_o} !== {1'b1, 32'h0000_0100, 1'b0}) begin
      n_fail++; $display("FAIL read_issue: got req=%b addr=%h we=%b expected 1 00000100 0", s_req_o, s_addr_o, s_we_o);
    end
    s_gnt_i = 1;
    #1;
    n_checks++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
      n_fail++; $display("FAIL read_gnt: got %b expected 10", {m0_gnt_o, m1_gnt_o});
    end
    cyc();
    s_gnt_i = 0; m0_req_i = 0;
    #1;
    n_checks++;
    if ({s_req_o, m0_gnt_o, m1_gnt_o} !== 3'b000) begin
      n_fail++; $display("FAIL read_after_gnt: got %b expected 000", {s_req_o, m0_gnt_o, m1_gnt_o});
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++;
      if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin
        n_fail++; $display("FAIL read_wait_%0d: got rvalid %b expected 00", k, {m0_rvalid_o, m1_rvalid_o});
      end
    end
    s_rvalid_i = 1; s_rdata_i = 32'hA5A5_5A5A;
    cyc();
    s_rvalid_i = 0; s_rdata_i = 0;
    n_checks++;
    if ({m0_rvalid_o, m0_rdata_o, m0_err_o} !== {1'b1, 32'hA5A5_5A5A, 1'b0}) begin
      n_fail++; $display("FAIL read_rsp: got v=%b d=%h e=%b expected 1 a5a55a5a 0", m0_rvalid_o, m0_rdata_o, m0_err_o);
    end
    n_checks++;
    if ({m1_rvalid_o, m1_rdata_o, m1_err_o, m1_gnt_o} !== 35'h0) begin
      n_fail++; $display("FAIL read_m1_quiet: got %h expected 0", {m1_rvalid_o, m1_rdata_o, m1_err_o, m1_gnt_o});
    end
    cyc();
    n_checks++;
    if (m0_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL read_rvalid_pulse: got %b expected 0", m0_rvalid_o);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h0000_0200;
    m1_req_i = 1; m1_addr_i = 32'h0000_0300;
    cyc();
    n_checks++;
    if (s_addr_o !== 32'h0000_0200) begin
      n_fail++; $display("FAIL arb_first_addr: got %h expected 00000200", s_addr_o);
    end
    s_gnt_i = 1; #1;
    n_checks++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
      n_fail++; $display("FAIL arb_first_gnt: got %b expected 10", {m0_gnt_o, m1_gnt_o});
    end
    cyc();
    s_gnt_i = 0; m0_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h1111_1111;
    cyc();
    s_rvalid_i = 0;
    n_checks++;
    if ({m0_rvalid_o, m0_rdata_o, m1_rvalid_o} !== {1'b1, 32'h1111_1111, 1'b0}) begin
      n_fail++; $display("FAIL arb_first_rsp: got %h expected 1111111110", {m0_rvalid_o, m0_rdata_o, m1_rvalid_o});
    end
    cyc();
    n_checks++;
    if ({s_req_o, s_addr_o} !== {1'b1, 32'h0000_0300}) begin
      n_fail++; $display("FAIL arb_second_issue: got req=%b addr=%h expected 1 00000300", s_req_o, s_addr_o);
    end
    s_gnt_i = 1; #1;
    n_checks++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
      n_fail++; $display("FAIL arb_second_gnt: got %b expected 01", {m0_gnt_o, m1_gnt_o});
    end
    cyc();
    s_gnt_i = 0; m1_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h2222_2222;
    cyc();
    s_rvalid_i = 0;
    n_checks++;
    if ({m1_rvalid_o, m1_rdata_o, m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'h2222_2222, 1'b0, 32'h1111_1111}) begin
      n_fail++; $display("FAIL arb_second_rsp: got m1 %b/%h m0 %b/%h expected 1/22222222 0/11111111",
                         m1_rvalid_o, m1_rdata_o, m0_rvalid_o, m0_rdata_o);
    end
    // lone m0 read so that port 0 is the one just served
    m0_req_i = 1; m0_addr_i = 32'h0000_0400;
    cyc();
    s_gnt_i = 1;
    cyc();
    s_gnt_i = 0; m0_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h3333_3333;
    cyc();
    s_rvalid_i = 0;
    m0_req_i = 1; m0_addr_i = 32'h0000_0500;
    m1_req_i = 1; m1_addr_i = 32'h0000_0600;
    cyc();
    n_checks++;
    if (s_addr_o !== 32'h0000_0600) begin
      n_fail++; $display("FAIL arb_rr_m1_first: got %h expected 00000600", s_addr_o);
    end
    s_gnt_i = 1; #1;
    n_checks++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
      n_fail++; $display("FAIL arb_rr_m1_gnt: got %b expected 01", {m0_gnt_o, m1_gnt_o});
    end
    cyc();
    s_gnt_i = 0; m1_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h4444_4444;
    cyc();
    s_rvalid_i = 0;
    n_checks++;
    if ({m1_rvalid_o, m1_rdata_o} !== {1'b1, 32'h4444_4444}) begin
      n_fail++; $display("FAIL arb_rr_m1_rsp: got %b/%h expected 1/44444444", m1_rvalid_o, m1_rdata_o);
    end
    cyc();
    n_checks++;
    if ({s_req_o, s_addr_o} !== {1'b1, 32'h0000_0500}) begin
      n_fail++; $display("FAIL arb_rr_m0_next: got req=%b addr=%h expected 1 00000500", s_req_o, s_addr_o);
    end
    s_gnt_i = 1;
    cyc();
    s_gnt_i = 0; m0_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h5555_5555;
    cyc();
    s_rvalid_i = 0;
    n_checks++;
    if ({m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'h5555_5555}) begin
      n_fail++; $display("FAIL arb_rr_m0_rsp: got %b/%h expected 1/55555555", m0_rvalid_o, m0_rdata_o);
    end
  endtask

  // runs straight after test_arbitration so m1_rdata starts at 44444444
  task automatic test_write();
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h0000_0040; m1_be_i = 4'h3; m1_wdata_i = 32'hCAFE_F00D;
    cyc();
    n_checks++;
    if ({s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o} !== {1'b1, 1'b1, 32'h0000_0040, 4'h3, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL wr_issue: got we=%b addr=%h be=%h wdata=%h", s_we_o, s_addr_o, s_be_o, s_wdata_o);
    end
    s_gnt_i = 1; s_illegal_write_i = 1; #1;
    n_checks++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
      n_fail++; $display("FAIL wr_gnt: got %b expected 01", {m0_gnt_o, m1_gnt_o});
    end
    cyc();
    s_gnt_i = 0; s_illegal_write_i = 0; m1_req_i = 0; m1_we_i = 0;
    s_rvalid_i = 1; s_rdata_i = 32'h7777_7777;
    n_checks++;
    if ({m1_rvalid_o, m1_err_o, m1_rdata_o} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL wr_rsp: got v=%b e=%b d=%h expected 1 1 00000000", m1_rvalid_o, m1_err_o, m1_rdata_o);
    end
    n_checks++;
    if ({m0_rvalid_o, m0_err_o} !== 2'b00) begin
      n_fail++; $display("FAIL wr_m0_quiet: got %b expected 00", {m0_rvalid_o, m0_err_o});
    end
    cyc();
    s_rvalid_i = 0;
    cyc();
    n_checks++;
    if ({m0_rvalid_o, m1_rvalid_o, m1_err_o, m1_rdata_o} !== 35'h0) begin
      n_fail++; $display("FAIL wr_stray_rvalid: got %h expected 0", {m0_rvalid_o, m1_rvalid_o, m1_err_o, m1_rdata_o});
    end
    // legal write from m0
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h0000_0080; m0_wdata_i = 32'h1234_5678;
    cyc();
    s_gnt_i = 1;
    cyc();
    s_gnt_i = 0; m0_req_i = 0; m0_we_i = 0;
    n_checks++;
    if ({m0_rvalid_o, m0_err_o} !== 2'b10) begin
      n_fail++; $display("FAIL wr_legal_rsp: got %b expected 10", {m0_rvalid_o, m0_err_o});
    end
    cyc();
  endtask

  task automatic test_gnt_stall();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h0000_1000;
    cyc();
    for (int k = 1; k <= 10; k++) begin
      n_checks++;
      if ({s_req_o, m0_gnt_o, m1_gnt_o} !== 3'b100) begin
        n_fail++; $display("FAIL stall_cycle_%0d: got %b expected 100", k, {s_req_o, m0_gnt_o, m1_gnt_o});
      end
      cyc();
    end
    s_gnt_i = 1; #1;
    n_checks++;
    if ({s_req_o, m0_gnt_o} !== 2'b11) begin
      n_fail++; $display("FAIL stall_gnt: got %b expected 11", {s_req_o, m0_gnt_o});
    end
    cyc();
    s_gnt_i = 0; m0_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'h5A5A_0000;
    cyc();
    s_rvalid_i = 0;
    n_checks++;
    if ({m0_rvalid_o, m0_rdata_o, m0_err_o} !== {1'b1, 32'h5A5A_0000, 1'b0}) begin
      n_fail++; $display("FAIL stall_rsp: got %b/%h/%b expected 1/5a5a0000/0", m0_rvalid_o, m0_rdata_o, m0_err_o);
    end
  endtask

  task automatic test_reset_mid_txn();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h0000_0700;
    cyc();
    rst_i = 1; #1;
    n_checks++;
    if (s_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_issue_req: got %b expected 0", s_req_o);
    end
    cyc();
    rst_i = 0;
    cyc();
    s_gnt_i = 1;
    cyc();
    s_gnt_i = 0; m0_req_i = 0;
    rst_i = 1; #1;
    n_checks++;
    if ({s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, s_addr_o} !== 37'h0) begin
      n_fail++; $display("FAIL rst_wait_outputs: got %h expected 0", {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, s_addr_o});
    end
    cyc();
    rst_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hBAD0_BAD0;
    cyc();
    s_rvalid_i = 0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o} !== 34'h0) begin
        n_fail++; $display("FAIL rst_late_rvalid_%0d: got %h expected 0", k, {m0_rvalid_o, m1_rvalid_o, m0_rdata_o});
      end
      cyc();
    end
    m0_req_i = 1; m0_addr_i = 32'h0000_0800;
    m1_req_i = 1; m1_addr_i = 32'h0000_0900;
    cyc();
    s_gnt_i = 1; #1;
    n_checks++;
    if ({s_addr_o, m0_gnt_o, m1_gnt_o} !== {32'h0000_0800, 2'b10}) begin
      n_fail++; $display("FAIL rst_port0_priority: got addr=%h gnt=%b expected 00000800 10", s_addr_o, {m0_gnt_o, m1_gnt_o});
    end
    cyc();
    s_gnt_i = 0;
    do_reset();
  endtask

`ifdef OBI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_req_i = 1; m0_addr_i = 32'h0000_0A00;
    cyc();
    s_gnt_i = 1;
    cyc();
    s_gnt_i = 0; m0_req_i = 0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      n_checks++;
      if (m0_rvalid_o !== 1'b0) begin
        n_fail++; $display("FAIL tmo_early_%0d: got %b expected 0", k, m0_rvalid_o);
      end
    end
    cyc();
    n_checks++;
    if ({m0_rvalid_o, m0_rdata_o, m0_err_o, m1_rvalid_o} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL tmo_rsp: got v=%b d=%h e=%b expected 1 deadbeef 1", m0_rvalid_o, m0_rdata_o, m0_err_o);
    end
  endtask
`endif

  initial begin
    rst_i = 1;
    clr_inputs();
    test_reset();
    test_single_read();
    test_arbitration();
    test_write();
    test_gnt_stall();
    test_reset_mid_txn();
`ifdef OBI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_qspi_arbiter.md
Name: obi_qspi_arbiter

Overview:
- Two-port round-robin OBI arbiter that shares the single QSPI flash controller (an OBI subordinate) between instruction fetch (port 0) and data (port 1).
- Sits between the core's two OBI manager ports and the QSPI controller.
- Registers the winning request, holds one transaction outstanding at a time and routes the response back to its owner.
- Flags illegal writes to the requester that issued them.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT_CYCLES, 1024, response timeout in cycles. Used only when OBI_ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- m0_req_i / m1_req_i  in  1  manager request
- m0_gnt_o / m1_gnt_o  out  1  manager grant
- m0_addr_i / m1_addr_i  in  ADDR_W  manager address
- m0_we_i / m1_we_i  in  1  write enable
- m0_be_i / m1_be_i  in  4  byte enables
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data
- m0_rvalid_o / m1_rvalid_o  out  1  response valid (single-cycle pulse)
- m0_rdata_o / m1_rdata_o  out  DATA_W  response data
- m0_err_o / m1_err_o  out  1  error, qualified by rvalid
- s_req_o  out  1  request to QSPI controller
- s_gnt_i  in  1  QSPI controller grant
- s_addr_o  out  ADDR_W  latched address
- s_we_o  out  1  latched write enable
- s_be_o  out  4  latched byte enables
- s_wdata_o  out  DATA_W  latched write data
- s_rvalid_i  in  1  controller response valid
- s_rdata_i  in  DATA_W  controller response data
- s_illegal_write_i  in  1  controller illegal-write flag

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset forces: state=IDLE; s_req_o=0; all mN_gnt_o=0; all mN_rvalid_o=0; all mN_err_o=0; mN_rdata_o=0; latched fields=0; last_owner=1, so port 0 wins first.
- Reset asserted mid-transaction drops s_req_o immediately and discards the response.
- States: IDLE, ISSUE, WAIT_RSP, WRESP.
- IDLE, no request: stay in IDLE.
- IDLE, any mN_req_i=1:
  - Pick the winner: a lone requester wins; if both request, the port != last_owner wins.
  - Latch the winner's addr/we/be/wdata, set owner=winner and last_owner=winner, go to ISSUE.
  - Issue latency from request to s_req_o is 1 cycle.
- ISSUE:
  - s_req_o=1 with the latched fields.
  - mN_gnt_o = (state==ISSUE) && s_gnt_i && owner==N. This is combinational; the loser's gnt stays 0.
  - Managers must hold their request stable until granted; the arbiter does not re-check the held fields.
  - On s_gnt_i: go to WAIT_RSP if the latched we=0. If we=1, capture err=s_illegal_write_i and go to WRESP.
  - Without s_gnt_i: stay in ISSUE. s_req_o stays high indefinitely.
- WAIT_RSP:
  - s_req_o=0.
  - s_rvalid_i is sampled starting the cycle after the grant; it is never sampled in ISSUE.
  - On s_rvalid_i: register s_rdata_i into owner's rdata, pulse owner's rvalid for 1 cycle next cycle with err=0, go to IDLE.
- WRESP:
  - Write completes on grant.
  - Next cycle: owner rvalid pulses 1 cycle, rdata=0, err=captured flag, then go to IDLE.
- The non-owner's rvalid/err stay 0 throughout. rdata of the non-owner holds its last value.
- A new arbitration may start in the same cycle the rvalid pulse is emitted, since the state is IDLE there. Back-to-back throughput is one transaction per 3 cycles plus controller latency.
- Simultaneous requests with port 0 just served: port 1 wins, then port 0 on the next arbitration. No starvation.

Optional Feature:
- OBI_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
  - When it reaches TIMEOUT_CYCLES without s_rvalid_i: owner receives rvalid, rdata=32'hDEAD_BEEF, err=1; go to IDLE.
  - s_rvalid_i in the same cycle as the timeout takes priority, giving a normal response.
- Undefined: no counter exists; WAIT_RSP waits indefinitely.

Test Plan:
- Reset, then m0 read addr 0x0000_0100. Controller grants at cycle 1 and returns rvalid with 0xA5A5_5A5A four cycles later -> m0_gnt_o pulses once; m0_rvalid_o=1 one cycle after s_rvalid_i with rdata 0xA5A5_5A5A, err=0; m1 outputs stay 0.
- m0 and m1 request reads in the same cycle after reset -> m0 served first. m1 is granted on the next arbitration with s_addr_o=m1_addr_i. A repeat of the simultaneous requests serves m1 before m0.
- m1 write to 0x0000_0040 with s_illegal_write_i=1 at grant -> m1_rvalid_o pulses the cycle after the grant with err=1, rdata=0; s_rvalid_i is ignored.
- Controller holds s_gnt_i=0 for 10 cycles -> s_req_o stays 1 and no manager gnt is issued. Grant on cycle 11 completes normally.
- rst_i asserted in WAIT_RSP, then a late s_rvalid_i -> all outputs 0 immediately, no rvalid to either manager, and the next request is arbitrated with port 0 priority.
- OBI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no s_rvalid_i -> owner rvalid 8 cycles after entering WAIT_RSP with rdata 0xDEAD_BEEF, err=1.
